logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, registered bitwise logic unit: applies one of eight two-input gate functions (AND, OR, NAND, NOR, XOR, XNOR, NOT A, NOT B) across WIDTH-bit operands. It has a valid/ready handshake on both sides and a single output register stage. An accumulate mode chains results through an internal register, and a saturating transaction counter records throughput. It is the vector/pipelined successor of the single-bit gate primitives and sits between a command source and any downstream consumer that can apply backpressure.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of transaction counter (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  source presents an operation
- in_ready  output  1  block can accept this cycle
- op  input  3  function: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 NOT B
- a  input  WIDTH  operand A (ignored when acc_en=1)
- b  input  WIDTH  operand B
- acc_en  input  1  use accumulator as operand A
- acc_clr  input  1  clear accumulator
- out_valid  output  1  y/flags hold a result
- out_ready  input  1  sink accepts result
- y  output  WIDTH  registered result
- zero  output  1  y == 0
- parity  output  1  XOR-reduction of y
- acc  output  WIDTH  accumulator register
- op_count  output  CNT_W  accepted transactions, saturating

## Operation
- Accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- in_ready = !out_valid || out_ready; combinational, with no dependency on in_valid.
- Operand A select: acc_en ? (acc_clr ? 0 : acc) : a. acc_clr is applied before operand selection in the same cycle.
- Result f(op, A, b) is bitwise over all WIDTH bits. NOT A/NOT B ignore the other operand.
- On accept: y <= f; zero <= (f == 0); parity <= ^f; acc <= f; out_valid <= 1; op_count <= op_count+1 unless all ones (saturates, never wraps).
- acc is updated on every accept, not only when acc_en=1, so the last result is always chainable.
- acc_clr without accept: acc <= 0. acc_clr with accept: acc <= f (f computed with A=0 if acc_en). y and out_valid are unaffected by acc_clr alone.
- Output transfer without accept: out_valid <= 0; y/zero/parity hold their last values.
- Output transfer with accept in the same cycle: the new result is loaded and out_valid stays 1. This gives full throughput of one op per cycle.
- Backpressure (out_valid && !out_ready): in_ready=0; y, flags, acc, op_count hold; a, b, op are not sampled.
- op, a, b, acc_en are sampled only on accept. Values in other cycles have no effect.

## Timing
- Latency: 1 cycle from accept to out_valid=1 with the result on y.
- Throughput: 1 result/cycle while out_ready=1.
- Reset (rst_n=0 at posedge): out_valid=0, y=0, zero=0, parity=0, acc=0, op_count=0. in_ready=1 in the cycle after reset.
- Reset mid-operation discards any pending result. The in-flight result is not presented after reset.
- All outputs are registered except in_ready.
- No X propagation: outputs are defined from the first post-reset cycle.

## Test plan
- WIDTH=8. a=0xF0, b=0x3C, out_ready=1, ops 000..111 on consecutive cycles -> y = 0x30, 0xFC, 0xCF, 0x03, 0xCC, 0x33, 0x0F, 0xC3, each one cycle after accept; op_count=8; out_valid continuously 1.
- XOR a=0x5A b=0x5A -> y=0x00, zero=1, parity=0. Then OR a=0x01 b=0x00 -> y=0x01, zero=0, parity=1.
- Accumulate: acc_clr=1, acc_en=1, op=OR, b=0x01. Then acc_en=1 OR with b=0x02, then b=0x80 -> y=0x01, 0x03, 0x83; acc=0x83.
- Backpressure: hold out_ready=0 after one accept -> in_ready=0, y stable, a/b changes ignored, op_count unchanged. Release out_ready -> next op accepted the same cycle, new y the next cycle.
- Counter saturation with CNT_W=2: 5 accepts -> op_count=3 and stays 3.
- Assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, y=0, acc=0, op_count=0, in_ready=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit bitwise logic unit.
// One of eight two-input gate functions is applied per bit and the result is
// held in a single output stage with valid/ready flow control on both sides.
// An accumulator register chains results back in as operand A, and a
// saturating counter records how many operations have been accepted.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             parity,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOTA = 3'b110;

   logic             out_valid_reg, out_valid_next;
   logic [WIDTH-1:0] y_reg, y_next;
   logic             zero_reg, zero_next;
   logic             parity_reg, parity_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic             accept;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] f_comb;

   // The output stage can take a new result when empty or when it drains this cycle.
   assign in_ready = !out_valid_reg || out_ready;
   assign accept   = in_valid && in_ready;

   // A clear in the same cycle wins over the stored accumulator value.
   assign opa = acc_en ? (acc_clr ? '0 : acc_reg) : a;

   // Per-bit gate evaluation; every bit uses the same function select.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic bit_f;

         // Select the gate function for this bit.
         always_comb begin
            bit_f = 1'b0;
            case (op)
               OP_AND:  bit_f = opa[gi] & b[gi];
               OP_OR:   bit_f = opa[gi] | b[gi];
               OP_NAND: bit_f = ~(opa[gi] & b[gi]);
               OP_NOR:  bit_f = ~(opa[gi] | b[gi]);
               OP_XOR:  bit_f = opa[gi] ^ b[gi];
               OP_XNOR: bit_f = ~(opa[gi] ^ b[gi]);
               OP_NOTA: bit_f = ~opa[gi];
               default: bit_f = ~b[gi];
            endcase
         end

         assign f_comb[gi] = bit_f;
      end
   endgenerate

   // Next-state for the output stage, accumulator and counter.
   always_comb begin
      out_valid_next = out_valid_reg;
      y_next         = y_reg;
      zero_next      = zero_reg;
      parity_next    = parity_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      if (accept) begin
         out_valid_next = 1'b1;
         y_next         = f_comb;
         zero_next      = ~|f_comb;
         parity_next    = ^f_comb;
         acc_next       = f_comb;
         if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + 1'b1;
         end
      end else begin
         if (acc_clr) begin
            acc_next = '0;
         end
         if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         y_reg         <= '0;
         zero_reg      <= 1'b0;
         parity_reg    <= 1'b0;
         acc_reg       <= '0;
         cnt_reg       <= '0;
      end else begin
         out_valid_reg <= out_valid_next;
         y_reg         <= y_next;
         zero_reg      <= zero_next;
         parity_reg    <= parity_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign y         = y_reg;
   assign zero      = zero_reg;
   assign parity    = parity_reg;
   assign acc       = acc_reg;
   assign op_count  = cnt_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: directed steps followed by random traffic,
// compared every cycle against a truth-table reference model.
module tb_logic_unit_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] op;
   logic [7:0] a, b;
   logic       acc_en, acc_clr, out_ready;

   logic        in_ready, out_valid, zero, parity;
   logic [7:0]  y, acc;
   logic [15:0] op_count;

   logic       s_in_ready, s_out_valid, s_zero, s_parity;
   logic [7:0] s_y, s_acc;
   logic [1:0] s_op_count;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic       m_valid;
   logic [7:0] m_y, m_acc;
   logic       m_zero, m_par;
   int         m_cnt;

   // truth tables indexed by {a_bit, b_bit}
   logic [3:0] tt_tab [8];

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .acc_en(acc_en), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
      .parity(parity), .acc(acc), .op_count(op_count)
   );

   logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_small (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .op(op), .a(a), .b(b), .acc_en(acc_en), .acc_clr(acc_clr),
      .out_valid(s_out_valid), .out_ready(out_ready), .y(s_y), .zero(s_zero),
      .parity(s_parity), .acc(s_acc), .op_count(s_op_count)
   );

   function automatic logic [7:0] ref_gate(input logic [2:0] f, input logic [7:0] x, input logic [7:0] z);
      logic [3:0] tt;
      logic [7:0] r;
      tt = tt_tab[f];
      for (int i = 0; i < 8; i++) r[i] = tt[{x[i], z[i]}];
      return r;
   endfunction

   function automatic logic ref_parity(input logic [7:0] v);
      int ones = 0;
      for (int i = 0; i < 8; i++) if (v[i]) ones++;
      return (ones % 2) == 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock with the inputs currently driven, update the model, check outputs.
   task automatic cycle(input string tag);
      logic       rdy, acc_now;
      logic [7:0] opa, f;
      #1;
      rdy = !m_valid || out_ready;
      chk({tag, ":in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 0; m_y = 0; m_zero = 0; m_par = 0; m_acc = 0; m_cnt = 0;
      end else begin
         acc_now = in_valid && rdy;
         if (acc_now) begin
            opa = acc_en ? (acc_clr ? 8'h00 : m_acc) : a;
            f = ref_gate(op, opa, b);
            m_y = f;
            m_zero = (f == 8'h00);
            m_par = ref_parity(f);
            m_acc = f;
            m_valid = 1;
            m_cnt++;
         end else begin
            if (acc_clr) m_acc = 8'h00;
            if (m_valid && out_ready) m_valid = 0;
         end
      end
      #1;
      chk({tag, ":out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
      chk({tag, ":y"}, {24'd0, y}, {24'd0, m_y});
      chk({tag, ":zero"}, {31'd0, zero}, {31'd0, m_zero});
      chk({tag, ":parity"}, {31'd0, parity}, {31'd0, m_par});
      chk({tag, ":acc"}, {24'd0, acc}, {24'd0, m_acc});
      chk({tag, ":op_count"}, {16'd0, op_count}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
      chk({tag, ":op_count_sat2"}, {30'd0, s_op_count}, (m_cnt > 3) ? 32'd3 : m_cnt);
      $display("step %s in_v=%0b op=%0d a=%h b=%h acc_en=%0b clr=%0b out_r=%0b -> out_v=%0b y=%h acc=%h cnt=%0d",
               tag, in_valid, op, a, b, acc_en, acc_clr, out_ready, out_valid, y, acc, op_count);
   endtask

   task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] z,
                        input logic ae, input logic ac, input logic r);
      in_valid = v; op = o; a = x; b = z; acc_en = ae; acc_clr = ac; out_ready = r;
   endtask

   logic [7:0] exp_y [8];
   logic [7:0] held_y;

   initial begin
      tt_tab[0] = 4'b1000; tt_tab[1] = 4'b1110; tt_tab[2] = 4'b0111; tt_tab[3] = 4'b0001;
      tt_tab[4] = 4'b0110; tt_tab[5] = 4'b1001; tt_tab[6] = 4'b0011; tt_tab[7] = 4'b0101;
      exp_y[0] = 8'h30; exp_y[1] = 8'hFC; exp_y[2] = 8'hCF; exp_y[3] = 8'h03;
      exp_y[4] = 8'hCC; exp_y[5] = 8'h33; exp_y[6] = 8'h0F; exp_y[7] = 8'hC3;
      m_valid = 0; m_y = 0; m_zero = 0; m_par = 0; m_acc = 0; m_cnt = 0;

      // reset
      rst_n = 0;
      drive(0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
      cycle("reset0");
      cycle("reset1");
      rst_n = 1;
      chk("post_reset:in_ready", {31'd0, in_ready}, 32'd1);

      // all eight functions back to back
      for (int i = 0; i < 8; i++) begin
         drive(1, 3'(i), 8'hF0, 8'h3C, 0, 0, 1);
         cycle($sformatf("op%0d", i));
         chk($sformatf("op%0d:y_const", i), {24'd0, y}, {24'd0, exp_y[i]});
         chk($sformatf("op%0d:valid_const", i), {31'd0, out_valid}, 32'd1);
      end
      chk("op_count_after8", {16'd0, op_count}, 32'd8);
      chk("op_count_sat2_after8", {30'd0, s_op_count}, 32'd3);

      // zero and parity flags
      drive(1, 3'd4, 8'h5A, 8'h5A, 0, 0, 1);
      cycle("xor_zero");
      chk("xor_zero:flags", {29'd0, y == 8'h00, zero, parity}, 32'b110);
      drive(1, 3'd1, 8'h01, 8'h00, 0, 0, 1);
      cycle("or_parity");
      chk("or_parity:flags", {24'd0, y}, 32'h01);

      // accumulate chain
      drive(1, 3'd1, 8'hFF, 8'h01, 1, 1, 1);
      cycle("acc_clr");
      drive(1, 3'd1, 8'hFF, 8'h02, 1, 0, 1);
      cycle("acc_or2");
      drive(1, 3'd1, 8'hFF, 8'h80, 1, 0, 1);
      cycle("acc_or80");
      chk("acc_chain:acc", {24'd0, acc}, 32'h83);

      // backpressure
      drive(1, 3'd4, 8'h0F, 8'hFF, 0, 0, 0);
      cycle("bp_accept");
      held_y = y;
      for (int i = 0; i < 3; i++) begin
         drive(1, 3'(i), 8'($urandom), 8'($urandom), 0, 0, 0);
         cycle($sformatf("bp_hold%0d", i));
         chk($sformatf("bp_hold%0d:y_stable", i), {24'd0, y}, {24'd0, held_y});
      end
      drive(1, 3'd0, 8'hAA, 8'h0F, 0, 0, 1);
      cycle("bp_release");
      chk("bp_release:y", {24'd0, y}, 32'h0A);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         drive(($urandom % 4) != 0, 3'($urandom), 8'($urandom), 8'($urandom),
               ($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 10) < 7);
         cycle($sformatf("rnd%0d", i));
      end

      // reset while a result is stalled
      drive(1, 3'd1, 8'h5A, 8'h00, 0, 0, 0);
      cycle("pre_rst_accept");
      drive(1, 3'd1, 8'h11, 8'h22, 0, 0, 0);
      cycle("pre_rst_stall");
      rst_n = 0;
      cycle("mid_reset");
      rst_n = 1;
      drive(0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
      #1;
      chk("mid_reset:out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_reset:y", {24'd0, y}, 32'd0);
      chk("mid_reset:acc", {24'd0, acc}, 32'd0);
      chk("mid_reset:op_count", {16'd0, op_count}, 32'd0);
      chk("mid_reset:in_ready", {31'd0, in_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
